// File: rtl/dac_sine_sequencer.sv
// dac_sine_sequencer: sample-tick divider, phase accumulator and quarter-wave ROM
// addressing with quadrant mirroring, amplitude scaling and DAC strobe generation.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no ticks, config loads straight into the active registers
// RUN      | ticking; config offers go to the staging register
// STOPPING | ticking until the wrap tick, whose sample is the last one
// PARK     | one cycle: drive midscale with a strobe, clear phase and busy
module dac_sine_sequencer #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 6,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [DATA_W-1:0]  amp,
    output logic [LUT_AW-1:0]  rom_addr,
    input  logic [DATA_W-2:0]  rom_data,
    output logic [DATA_W-1:0]  dac_data,
    output logic               dac_strobe,
    output logic               busy
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int PROD_W = 2 * DATA_W - 1;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2,
        S_PARK     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [PHASE_W-1:0]  freq_act_q, freq_act_d;
    logic [DATA_W-1:0]   amp_act_q, amp_act_d;
    logic [PHASE_W-1:0]  stg_freq_q, stg_freq_d;
    logic [DATA_W-1:0]   stg_amp_q, stg_amp_d;
    logic                staged_q, staged_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [LUT_AW-1:0]   rom_addr_q, rom_addr_d;
    logic                sign_q, sign_d;
    logic [DATA_W-1:0]   amp_s_q, amp_s_d;
    logic                last_q, last_d;
    logic                v1_q, v1_d;
    logic                v2_q, v2_d;
    logic [DATA_W-1:0]   dac_data_q, dac_data_d;
    logic                strobe_q, strobe_d;
    logic                busy_q, busy_d;

    logic                running;
    logic                tick;
    logic [PHASE_W:0]    sum_w;
    logic                wrap_eff;
    logic [LUT_AW-1:0]   idx_w;
    logic                cfg_fire;
    logic                cfg_direct;
    logic [PROD_W-1:0]   prod_w;
    logic [DATA_W-2:0]   mag_w;

    assign running    = (state_q == S_RUN) || (state_q == S_STOPPING);
    assign tick       = running && (div_q == '0);
    assign sum_w      = {1'b0, phase_q} + {1'b0, freq_act_q};
    // A zero increment never carries, so every tick counts as a period boundary.
    assign wrap_eff   = sum_w[PHASE_W] || (freq_act_q == '0);
    assign idx_w      = phase_q[PHASE_W-3 -: LUT_AW];
    assign cfg_ready  = ~staged_q;
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign cfg_direct = (state_q == S_IDLE) || (state_q == S_PARK);
    assign prod_w     = PROD_W'(rom_data) * PROD_W'(amp_s_q);
    assign mag_w      = (DATA_W-1)'(prod_w >> DATA_W);

    // Next-state logic of the run/stop sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start && !stop) state_d = S_RUN;
            S_RUN:      if (stop) state_d = S_STOPPING;
            S_STOPPING: if (v2_q && last_q) state_d = S_PARK;
            S_PARK:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Divider, phase accumulator, config staging and the two-stage sample pipeline.
    always_comb begin
        phase_d    = phase_q;
        freq_act_d = freq_act_q;
        amp_act_d  = amp_act_q;
        stg_freq_d = stg_freq_q;
        stg_amp_d  = stg_amp_q;
        staged_d   = staged_q;
        div_d      = div_q;
        rom_addr_d = rom_addr_q;
        sign_d     = sign_q;
        amp_s_d    = amp_s_q;
        last_d     = last_q;
        v1_d       = tick;
        v2_d       = v1_q;
        dac_data_d = dac_data_q;
        strobe_d   = 1'b0;
        busy_d     = busy_q;

        if (state_q == S_IDLE && state_d == S_RUN) begin
            div_d  = '0;
            busy_d = 1'b1;
        end else if (tick) begin
            div_d = DIV_W'(CLK_DIV - 1);
        end else if (running) begin
            div_d = div_q - DIV_W'(1);
        end

        if (cfg_fire) begin
            if (cfg_direct) begin
                freq_act_d = freq_word;
                amp_act_d  = amp;
            end else begin
                stg_freq_d = freq_word;
                stg_amp_d  = amp;
                staged_d   = 1'b1;
            end
        end

        // The sample's amplitude is captured at its tick so a config swap on the
        // wrap tick cannot alter the wrap sample itself.
        if (tick) begin
            rom_addr_d = phase_q[PHASE_W-2] ? ~idx_w : idx_w;
            sign_d     = phase_q[PHASE_W-1];
            amp_s_d    = amp_act_q;
            phase_d    = sum_w[PHASE_W-1:0];
            last_d     = (state_q == S_STOPPING) && wrap_eff;
            if (wrap_eff && staged_q) begin
                freq_act_d = stg_freq_q;
                amp_act_d  = stg_amp_q;
                staged_d   = 1'b0;
            end
        end

        if (v2_q) begin
            dac_data_d = sign_q ? (MID - {1'b0, mag_w}) : (MID + {1'b0, mag_w});
            strobe_d   = 1'b1;
        end

        if (state_q == S_PARK) begin
            dac_data_d = MID;
            strobe_d   = 1'b1;
            busy_d     = 1'b0;
            phase_d    = '0;
            last_d     = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            freq_act_q <= '0;
            amp_act_q  <= '0;
            stg_freq_q <= '0;
            stg_amp_q  <= '0;
            staged_q   <= 1'b0;
            div_q      <= '0;
            rom_addr_q <= '0;
            sign_q     <= 1'b0;
            amp_s_q    <= '0;
            last_q     <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            dac_data_q <= MID;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            freq_act_q <= freq_act_d;
            amp_act_q  <= amp_act_d;
            stg_freq_q <= stg_freq_d;
            stg_amp_q  <= stg_amp_d;
            staged_q   <= staged_d;
            div_q      <= div_d;
            rom_addr_q <= rom_addr_d;
            sign_q     <= sign_d;
            amp_s_q    <= amp_s_d;
            last_q     <= last_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            dac_data_q <= dac_data_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign dac_data   = dac_data_q;
    assign dac_strobe = strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dac_sine_sequencer.sv
// Testbench for dac_sine_sequencer: directed runs with a table of hand-computed
// samples plus a per-sample reference check, and sequences for stop/park/reset corners.
module tb_dac_sine_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] freq_word;
    logic [7:0]  amp;
    logic [5:0]  rom_addr;
    logic [6:0]  rom_data;
    logic [7:0]  dac_data;
    logic        dac_strobe;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [6:0] rom_tbl [64];
    int q_data[$];
    int q_addr[$];
    int q_cyc[$];

    typedef struct {
        int run;
        int k;
        int exp_addr;
        int exp_code;
    } vec_t;
    vec_t tbl [21];

    dac_sine_sequencer #(
        .DATA_W(8), .PHASE_W(16), .LUT_AW(6), .CLK_DIV(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .freq_word(freq_word), .amp(amp),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .dac_data(dac_data), .dac_strobe(dac_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    // cyc holds the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Quarter-wave ROM with a one-cycle synchronous read.
    always @(posedge clk) rom_data <= rom_tbl[rom_addr];

    // Log every strobe with its data, the held ROM address and the edge count.
    always @(negedge clk) begin
        if (dac_strobe) begin
            q_data.push_back(int'(dac_data));
            q_addr.push_back(int'(rom_addr));
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_phase(input int r, input int k);
        if (r == 0) return (k * 'h400) & 'hFFFF;
        if (k < 16) return (k * 'h1000) & 'hFFFF;
        return ((k - 16) * 'h800) & 'hFFFF;
    endfunction

    function automatic int exp_amp(input int r, input int k);
        if (r == 0) return 255;
        return (k < 16) ? 0 : 255;
    endfunction

    function automatic int model_addr(input int ph);
        int q;
        int idx;
        q   = (ph >> 14) & 3;
        idx = (ph >> 8) & 63;
        return ((q & 1) != 0) ? (63 - idx) : idx;
    endfunction

    function automatic int model_code(input int ph, input int a);
        int mag;
        mag = (int'(rom_tbl[model_addr(ph)]) * a) >> 8;
        return (((ph >> 14) & 2) != 0) ? (128 - mag) : (128 + mag);
    endfunction

    task automatic wait_count(input int n, input int budget, input string what);
        int i = 0;
        while (q_data.size() < n && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (q_data.size() < n) check(what, q_data.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string what);
        int i = 0;
        while (busy && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (busy) check(what, int'(busy), 0);
    endtask

    task automatic kick(input logic [15:0] f, input logic [7:0] a, output int s);
        @(negedge clk);
        start     = 1'b1;
        cfg_valid = 1'b1;
        freq_word = f;
        amp       = a;
        s         = cyc + 1;
        @(negedge clk);
        start     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic clear_log();
        q_data.delete();
        q_addr.delete();
        q_cyc.delete();
    endtask

    task automatic check_run(input int r, input int s, input int nsamp);
        for (int i = 0; i < 21; i++) begin
            if (tbl[i].run == r) begin
                if (tbl[i].k < q_data.size()) begin
                    check($sformatf("run%0d k%0d rom_addr", r, tbl[i].k),
                          q_addr[tbl[i].k], tbl[i].exp_addr);
                    if (tbl[i].exp_code >= 0)
                        check($sformatf("run%0d k%0d dac_data", r, tbl[i].k),
                              q_data[tbl[i].k], tbl[i].exp_code);
                    check($sformatf("run%0d k%0d strobe cycle", r, tbl[i].k),
                          q_cyc[tbl[i].k], s + 3 + 4 * tbl[i].k);
                end else begin
                    check($sformatf("run%0d k%0d present", r, tbl[i].k),
                          q_data.size(), tbl[i].k + 1);
                end
            end
        end
        for (int k = 0; k < nsamp && k < q_data.size(); k++) begin
            check($sformatf("run%0d model addr k%0d", r, k), q_addr[k],
                  model_addr(exp_phase(r, k)));
            check($sformatf("run%0d model code k%0d", r, k), q_data[k],
                  model_code(exp_phase(r, k), exp_amp(r, k)));
        end
    endtask

    task automatic check_park(input string name, input int n_exp);
        check({name, " strobe count"}, q_data.size(), n_exp);
        if (q_data.size() == n_exp) begin
            check({name, " park code"}, q_data[n_exp-1], 'h80);
            check({name, " park follows last sample"}, q_cyc[n_exp-1] - q_cyc[n_exp-2], 1);
        end
        check({name, " busy after park"}, int'(busy), 0);
        check({name, " dac held at mid"}, int'(dac_data), 'h80);
    endtask

    initial begin
        int s;
        int n_before;

        for (int i = 0; i < 64; i++)
            rom_tbl[i] = 7'($rtoi(127.0 * $sin(3.14159265358979 * i / 126.0) + 0.5));

        // run | k | rom_addr | code (-1: address only, code via reference)
        tbl[0]  = '{0,   0,  0, 'h80};
        tbl[1]  = '{0,   1,  4, -1};
        tbl[2]  = '{0,  15, 60, -1};
        tbl[3]  = '{0,  16, 63, 'hFE};
        tbl[4]  = '{0,  17, 59, -1};
        tbl[5]  = '{0,  32,  0, 'h80};
        tbl[6]  = '{0,  33,  4, -1};
        tbl[7]  = '{0,  48, 63, 'h02};
        tbl[8]  = '{0,  63,  3, -1};
        tbl[9]  = '{0,  64,  0, 'h80};
        tbl[10] = '{0,  80, 63, 'hFE};
        tbl[11] = '{0, 127,  3, -1};
        tbl[12] = '{1,   0,  0, 'h80};
        tbl[13] = '{1,   4, 63, 'h80};
        tbl[14] = '{1,   8,  0, 'h80};
        tbl[15] = '{1,  15, 15, 'h80};
        tbl[16] = '{1,  16,  0, 'h80};
        tbl[17] = '{1,  17,  8, -1};
        tbl[18] = '{1,  24, 63, 'hFE};
        tbl[19] = '{1,  40, 63, 'h02};
        tbl[20] = '{1,  47,  7, -1};

        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        freq_word = '0; amp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset dac_data", int'(dac_data), 'h80);
        check("reset dac_strobe", int'(dac_strobe), 0);
        check("reset busy", int'(busy), 0);
        check("reset cfg_ready", int'(cfg_ready), 1);
        check("reset rom_addr", int'(rom_addr), 0);
        rst = 1'b0;

        // Full-scale sine, stop requested mid-period, park after the wrap sample.
        clear_log();
        kick(16'h0400, 8'hFF, s);
        wait_count(10, 100, "runA early samples");
        check("runA busy", int'(busy), 1);
        check("runA cfg_ready", int'(cfg_ready), 1);
        wait_count(96, 600, "runA samples before stop");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(400, "runA busy drop");
        repeat (4) @(negedge clk);
        #1;
        check_run(0, s, 128);
        check_park("runA", 129);

        // Zero amplitude, then a reconfiguration staged until the wrap.
        clear_log();
        kick(16'h1000, 8'h00, s);
        wait_count(6, 100, "runB early samples");
        check("runB busy", int'(busy), 1);
        @(negedge clk);
        check("runB cfg_ready before offer", int'(cfg_ready), 1);
        cfg_valid = 1'b1; freq_word = 16'h0800; amp = 8'hFF;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        check("runB cfg_ready staged", int'(cfg_ready), 0);
        wait_count(15, 100, "runB pre-wrap samples");
        check("runB cfg_ready held until wrap", int'(cfg_ready), 0);
        wait_count(16, 100, "runB wrap sample");
        check("runB cfg_ready after wrap", int'(cfg_ready), 1);
        wait_count(20, 100, "runB samples before stop");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(400, "runB busy drop");
        repeat (4) @(negedge clk);
        #1;
        check_run(1, s, 48);
        check_park("runB", 49);

        // start and stop together in IDLE: stop wins.
        clear_log();
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("start+stop strobes", q_data.size(), 0);
        check("start+stop busy", int'(busy), 0);

        // Zero frequency: the first tick in STOPPING ends the run.
        clear_log();
        kick(16'h0000, 8'hFF, s);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(100, "freq0 busy drop");
        repeat (4) @(negedge clk);
        #1;
        check("freq0 strobe count", q_data.size(), 3);
        if (q_data.size() == 3) begin
            check("freq0 first strobe cycle", q_cyc[0], s + 3);
            check("freq0 last sample cycle", q_cyc[1], s + 7);
            check("freq0 park cycle", q_cyc[2], s + 8);
            check("freq0 sample code", q_data[1], 'h80);
            check("freq0 park code", q_data[2], 'h80);
            check("freq0 sample addr", q_addr[1], 0);
        end

        // Reset with a sample in flight: nothing is strobed afterwards.
        clear_log();
        kick(16'h0400, 8'hFF, s);
        wait_count(2, 50, "rst-run samples");
        while (cyc < s + 9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_before = q_data.size();
        check("rst-run strobes before reset", n_before, 2);
        repeat (20) @(negedge clk);
        #1;
        check("rst-run strobes after reset", q_data.size(), n_before);
        check("rst-run dac_data", int'(dac_data), 'h80);
        check("rst-run busy", int'(busy), 0);
        check("rst-run rom_addr", int'(rom_addr), 0);
        check("rst-run cfg_ready", int'(cfg_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
